// File: rtl/alu_issue_pkg.sv
// Shared RV32I opcode/funct constants and decode helpers for the ALU issue unit.
// This package is the common home for the opcode and funct constants.
package alu_issue_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

    localparam logic [2:0] FUNCT3_ADD = 3'b000;
    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SR  = 3'b101;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == FUNCT3_SLL) || (f3 == FUNCT3_SR);
    endfunction

    function automatic logic instr_legal(input logic [6:0] opcode, input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic ok;
        ok = 1'b0;
        if (opcode == OPCODE_OP) begin
            ok = (f7 == FUNCT7_BASE) ||
                 ((f7 == FUNCT7_ALT) && ((f3 == FUNCT3_ADD) || (f3 == FUNCT3_SR)));
        end else if (opcode == OPCODE_OP_IMM) begin
            // Only shifts constrain imm[11:5]; every other OP-IMM funct3 is legal.
            if (f3 == FUNCT3_SLL) begin
                ok = (f7 == FUNCT7_BASE);
            end else if (f3 == FUNCT3_SR) begin
                ok = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
            end else begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the immediate field selected by the opcode.
// I-type is the default; S and U formats are decoded so more formats slot in here.
module imm_gen
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (instr[6:0])
            OPCODE_STORE: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPCODE_LUI:   imm = {instr[31:12], 12'b0};
            default:      imm = {{20{instr[31]}}, instr[31:20]};
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue unit for RV32I OP/OP-IMM instructions: latch, decode, read operands,
// strobe the ALU and write the result back, one instruction every four cycles.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        rf_rd_en,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic        alu_en,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        src_sel,
    output logic [31:0] reg_data_1,
    output logic [31:0] reg_data_2,
    output logic [31:0] immediate,
    input  logic [31:0] alu_res,
    output logic        rf_we,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data,
    output logic        retire,
    output logic        illegal
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

    state_e      state_q;
    logic [31:0] instr_q;
    logic        alu_en_q, src_sel_q, retire_q, rf_we_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic [4:0]  wr_addr_q;
    logic [31:0] imm_q, reg1_q, reg2_q;
    logic [31:0] imm_dec;
    logic        legal, is_op;

    assign is_op = (instr_q[6:0] == OPCODE_OP);
    assign legal = instr_legal(instr_q[6:0], instr_q[14:12], instr_q[31:25]);

    imm_gen u_imm_gen (
        .instr (instr_q),
        .imm   (imm_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            alu_en_q  <= 1'b0;
            src_sel_q <= 1'b0;
            retire_q  <= 1'b0;
            rf_we_q   <= 1'b0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            wr_addr_q <= '0;
            imm_q     <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (legal) begin
                        state_q   <= StExec;
                        alu_en_q  <= 1'b1;
                        funct3_q  <= instr_q[14:12];
                        // Non-shift OP-IMM forces funct7 to zero so ADDI never subtracts.
                        funct7_q  <= (is_op || is_shift(instr_q[14:12])) ? instr_q[31:25]
                                                                         : FUNCT7_BASE;
                        src_sel_q <= is_op;
                        imm_q     <= imm_dec;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StExec: begin
                    state_q   <= StWb;
                    alu_en_q  <= 1'b0;
                    reg1_q    <= rf_rs1_data;
                    reg2_q    <= rf_rs2_data;
                    retire_q  <= 1'b1;
                    rf_we_q   <= (instr_q[11:7] != 5'd0);
                    wr_addr_q <= instr_q[11:7];
                end
                StWb: begin
                    state_q   <= StIdle;
                    retire_q  <= 1'b0;
                    rf_we_q   <= 1'b0;
                    wr_addr_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign rf_rd_en    = (state_q == StDecode);
    assign rf_rs1_addr = instr_q[19:15];
    assign rf_rs2_addr = instr_q[24:20];
    assign illegal     = (state_q == StDecode) && !legal;
    assign alu_en      = alu_en_q;
    assign funct3      = funct3_q;
    assign funct7      = funct7_q;
    assign src_sel     = src_sel_q;
    assign immediate   = imm_q;
    // Register-file data arrives during EXEC; a held copy keeps the operands stable in WB.
    assign reg_data_1  = (state_q == StExec) ? rf_rs1_data : reg1_q;
    assign reg_data_2  = (state_q == StExec) ? rf_rs2_data : reg2_q;
    assign rf_we       = rf_we_q;
    assign rf_wr_addr  = wr_addr_q;
    assign rf_wr_data  = (state_q == StWb) ? alu_res : '0;
    assign retire      = retire_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a simple register-file read model and ALU model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready, rf_rd_en, alu_en, src_sel, rf_we, retire, illegal;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr, rf_wr_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data, reg_data_1, reg_data_2, immediate;
    logic [31:0] alu_res, rf_wr_data;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [31:0] regs [32];
    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int ret_cnt = 0;
    int xfer_cnt = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_rd_en    (rf_rd_en),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .alu_en      (alu_en),
        .funct3      (funct3),
        .funct7      (funct7),
        .src_sel     (src_sel),
        .reg_data_1  (reg_data_1),
        .reg_data_2  (reg_data_2),
        .immediate   (immediate),
        .alu_res     (alu_res),
        .rf_we       (rf_we),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .retire      (retire),
        .illegal     (illegal)
    );

    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return f7[5] ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'b0, $signed(a) < $signed(b)};
            3'd3:    return {31'b0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Register file returns read data one cycle after rf_rd_en; ALU result one cycle after alu_en.
    always_ff @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rs1_data <= regs[rf_rs1_addr];
            rf_rs2_data <= regs[rf_rs2_addr];
        end
        if (alu_en) alu_res <= alu_model(funct3, funct7, reg_data_1,
                                         src_sel ? reg_data_2 : immediate);
        if (rf_we) we_cnt <= we_cnt + 1;
        if (retire) ret_cnt <= ret_cnt + 1;
        if (instr_valid && instr_ready && rst_n) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 8 && instr_ready !== 1'b1; i++) @(negedge clk);
        check({tag, ".ready_wait"}, {31'b0, instr_ready}, 32'd1);
    endtask

    // Offers one legal instruction and checks every stage; starts and ends at a negedge in IDLE.
    task automatic run_op(input string tag, input logic [31:0] word, input logic [6:0] exp_f7,
                          input logic exp_src, input logic [31:0] exp_imm,
                          input logic [31:0] exp_r1, input logic exp_we, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data);
        wait_ready(tag);
        instr = word;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        instr = 32'hFFFF_FFFF;
        @(negedge clk);
        check({tag, ".decode"}, {29'b0, rf_rd_en, instr_ready, illegal}, 32'b100);
        check({tag, ".rs_addr"}, {22'b0, rf_rs1_addr, rf_rs2_addr}, {22'b0, word[19:15], word[24:20]});
        @(negedge clk);
        check({tag, ".exec_ctl"}, {24'b0, alu_en, src_sel, funct3, rf_rd_en, retire, rf_we},
              {24'b0, 1'b1, exp_src, word[14:12], 3'b000});
        check({tag, ".funct7"}, {25'b0, funct7}, {25'b0, exp_f7});
        check({tag, ".imm"}, immediate, exp_imm);
        check({tag, ".rd1"}, reg_data_1, exp_r1);
        @(negedge clk);
        check({tag, ".wb_ctl"}, {28'b0, alu_en, retire, rf_we, src_sel}, {28'b0, 1'b0, 1'b1, exp_we, exp_src});
        check({tag, ".wb_addr"}, {27'b0, rf_wr_addr}, {27'b0, exp_rd});
        check({tag, ".wb_data"}, rf_wr_data, exp_data);
        check({tag, ".hold_f7"}, {25'b0, funct7}, {25'b0, exp_f7});
        @(negedge clk);
        check({tag, ".ready_again"}, {30'b0, instr_ready, retire}, 32'b10);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] word);
        int we0;
        int ret0;
        we0 = we_cnt;
        ret0 = ret_cnt;
        wait_ready(tag);
        instr = word;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check({tag, ".illegal"}, {29'b0, illegal, alu_en, instr_ready}, 32'b100);
        @(negedge clk);
        check({tag, ".back_idle"}, {29'b0, illegal, alu_en, instr_ready}, 32'b001);
        repeat (2) @(negedge clk);
        check({tag, ".no_effect"}, we_cnt + ret_cnt, we0 + ret0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we0;
        int ret0;
        int xf0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_ctl", {24'b0, instr_ready, rf_rd_en, alu_en, src_sel, rf_we, retire, illegal, 1'b0},
              32'h80);
        check("reset_addr", {17'b0, rf_rs1_addr, rf_rs2_addr, rf_wr_addr}, 32'd0);
        check("reset_data", reg_data_1 | reg_data_2 | immediate | rf_wr_data | {25'b0, funct7}, 32'd0);
        instr = 32'h0020_81B3;
        instr_valid = 1'b1;
        @(negedge clk);
        check("reset_no_xfer", {31'b0, rf_rd_en}, 32'd0);
        rst_n = 1'b1;

        run_op("add", 32'h0020_81B3, 7'h00, 1'b1, 32'h0000_0002, 32'd5, 1'b1, 5'd3, 32'd12);
        run_op("addi", 32'hFFF0_8213, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 5'd4, 32'd4);
        run_op("sub", 32'h4020_81B3, 7'h20, 1'b1, 32'h0000_0402, 32'd5, 1'b1, 5'd3, 32'hFFFF_FFFE);
        run_op("add_x0", 32'h0020_8033, 7'h00, 1'b1, 32'h0000_0002, 32'd5, 1'b0, 5'd0, 32'd12);
        regs[1] = 32'h8000_0000;
        run_op("srai", 32'h4040_D293, 7'h20, 1'b0, 32'h0000_0404, 32'h8000_0000, 1'b1, 5'd5,
               32'hF800_0000);
        run_illegal("load_opc", 32'h0000_2003);
        run_illegal("op_alt_sll", 32'h4020_9033);
        run_illegal("slli_alt", 32'h4010_9093);

        // Reset asserted during EXEC aborts the instruction.
        we0 = we_cnt;
        ret0 = ret_cnt;
        instr = 32'h0020_81B3;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_exec_pre", {31'b0, alu_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_exec_low", {29'b0, instr_ready, alu_en, rf_we}, 32'b100);
        repeat (2) @(negedge clk);
        check("rst_exec_hold", {29'b0, instr_ready, retire, illegal}, 32'b100);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_exec_abort", we_cnt + ret_cnt, we0 + ret0);

        // Back-to-back offers are accepted only every fourth cycle.
        xf0 = xfer_cnt;
        ret0 = ret_cnt;
        regs[1] = 32'd5;
        instr = 32'h0020_81B3;
        instr_valid = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("b2b_xfers", xfer_cnt - xf0, 32'd3);
        check("b2b_retires", ret_cnt - ret0, 32'd3);
        check("b2b_idle", {31'b0, instr_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
